// File: rtl/phase_angle_calc_if.sv
// -----------------------------------------------------------------------------
// phase_angle_calc_if
//   Handshake bundle for phase_angle_calc. It carries both the operand side
//   (valid/ready plus diff and period counts) and the result side (valid/ready
//   plus angle and status flags).
//
//   Signals:
//     in_valid      operands present (master -> slave)
//     in_ready      block can accept operands (slave -> master)
//     diff_count    phase-difference count, CNT_W bits
//     period_count  signal period count, CNT_W bits
//     out_valid     result present (slave -> master)
//     out_ready     consumer accepts result (master -> slave)
//     phase_deg     angle in degrees * 2^FRAC_BITS, ANGLE_W bits
//     sat           diff_count >= period_count, result clamped
//     err           period_count == 0, result forced to 0
//
//   Modports:
//     slave   the angle calculator
//     master  the producer/consumer driving it
// -----------------------------------------------------------------------------
interface phase_angle_calc_if #(
    parameter int CNT_W   = 64,
    parameter int ANGLE_W = 17
) ();
    logic               in_valid;
    logic               in_ready;
    logic [CNT_W-1:0]   diff_count;
    logic [CNT_W-1:0]   period_count;
    logic               out_valid;
    logic               out_ready;
    logic [ANGLE_W-1:0] phase_deg;
    logic               sat;
    logic               err;

    modport slave (
        input  in_valid, diff_count, period_count, out_ready,
        output in_ready, out_valid, phase_deg, sat, err
    );

    modport master (
        output in_valid, diff_count, period_count, out_ready,
        input  in_ready, out_valid, phase_deg, sat, err
    );
endinterface

// File: rtl/phase_angle_calc.sv
// -----------------------------------------------------------------------------
// phase_angle_calc
//   Converts a phase-difference count and the matching period count into an
//   unsigned fixed-point angle: phase_deg = diff * 360 * 2^FRAC_BITS / period.
//   A multi-cycle restoring divider produces one quotient bit per clock.
//
//   Ports:
//     sysClk   single clock
//     sysRst   synchronous active-high reset
//     bus      phase_angle_calc_if.slave (operand and result handshakes)
//
//   Optional feature:
//     PHASE_ANGLE_ROUND_EN  when defined, the final quotient is rounded to
//                           nearest (half up) instead of truncated, clamped to
//                           the largest representable angle below 360 degrees.
// -----------------------------------------------------------------------------
module phase_angle_calc #(
    parameter int CNT_W     = 64,
    parameter int FRAC_BITS = 8,
    parameter int ANGLE_W   = 9 + FRAC_BITS
) (
    input  logic                 sysClk,
    input  logic                 sysRst,
    phase_angle_calc_if.slave    bus
);

    // Numerator width: diff * 360 needs 9 extra bits, plus the fraction shift.
    localparam int NUM_W = CNT_W + 9 + FRAC_BITS;
    localparam int KW    = $clog2(ANGLE_W);
    localparam logic [ANGLE_W-1:0] MAX_DEG = ANGLE_W'((360 << FRAC_BITS) - 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_diff;
    logic [CNT_W-1:0]   r_period;
    logic [NUM_W-1:0]   r_rem;
    logic [NUM_W-1:0]   r_dvs;      // period << k, shifted right once per step
    logic [KW-1:0]      r_k;
    logic [ANGLE_W-1:0] r_q;
    logic [ANGLE_W-1:0] r_phase;
    logic               r_sat;
    logic               r_err;

    // ---------------------------------------------------------------------
    // Numerator: (diff * 360) << FRAC_BITS, with 360 = 256 + 64 + 32 + 8.
    // ---------------------------------------------------------------------
    logic [NUM_W-1:0] w_diff_ext;
    logic [NUM_W-1:0] w_x360;
    logic [NUM_W-1:0] w_num;
    logic [NUM_W-1:0] w_dvs_init;

    assign w_diff_ext = {{(NUM_W-CNT_W){1'b0}}, r_diff};
    assign w_x360     = (w_diff_ext << 8) + (w_diff_ext << 6)
                      + (w_diff_ext << 5) + (w_diff_ext << 3);
    assign w_num      = w_x360 << FRAC_BITS;
    assign w_dvs_init = {{(NUM_W-CNT_W){1'b0}}, r_period} << (ANGLE_W - 1);

    // ---------------------------------------------------------------------
    // One restoring-division step. Because diff < period on this path, the
    // numerator is below period << ANGLE_W, so each step yields one valid
    // quotient bit and the remainder never needs more than NUM_W bits.
    // ---------------------------------------------------------------------
    logic               w_ge;
    logic [NUM_W-1:0]   w_rem_nxt;
    logic [ANGLE_W-1:0] w_q_nxt;
    logic [ANGLE_W-1:0] w_q_final;
    logic               w_last;

    assign w_ge      = (r_rem >= r_dvs);
    assign w_rem_nxt = w_ge ? (r_rem - r_dvs) : r_rem;
    assign w_q_nxt   = r_q | (ANGLE_W'(w_ge) << r_k);
    assign w_last    = (r_k == '0);

`ifdef PHASE_ANGLE_ROUND_EN
    // Round half up using the final remainder; the clamp keeps the angle
    // strictly below 360 degrees.
    logic [NUM_W:0] w_rem2;
    logic           w_round_up;

    assign w_rem2     = {w_rem_nxt, 1'b0};
    assign w_round_up = (w_rem2 >= {1'b0, {(NUM_W-CNT_W){1'b0}}, r_period});
    assign w_q_final  = (w_round_up && (w_q_nxt != MAX_DEG))
                      ? (w_q_nxt + ANGLE_W'(1)) : w_q_nxt;
`else
    assign w_q_final  = w_q_nxt;
`endif

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge sysClk) begin
        if (sysRst) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // ---------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ---------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = MULT;
            end
            MULT: begin
                if ((r_period == '0) || (r_diff >= r_period)) w_state_nxt = DONE;
                else                                          w_state_nxt = DIV;
            end
            DIV: begin
                if (w_last) w_state_nxt = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath
    // ---------------------------------------------------------------------
    always_ff @(posedge sysClk) begin
        if (sysRst) begin
            r_diff   <= '0;
            r_period <= '0;
            r_rem    <= '0;
            r_dvs    <= '0;
            r_k      <= '0;
            r_q      <= '0;
            r_phase  <= '0;
            r_sat    <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_diff   <= bus.diff_count;
                        r_period <= bus.period_count;
                    end
                end
                MULT: begin
                    if (r_period == '0) begin
                        r_err   <= 1'b1;
                        r_sat   <= 1'b0;
                        r_phase <= '0;
                    end else if (r_diff >= r_period) begin
                        r_sat   <= 1'b1;
                        r_err   <= 1'b0;
                        r_phase <= MAX_DEG;
                    end else begin
                        r_rem <= w_num;
                        r_dvs <= w_dvs_init;
                        r_k   <= KW'(ANGLE_W - 1);
                        r_q   <= '0;
                    end
                end
                DIV: begin
                    r_rem <= w_rem_nxt;
                    r_q   <= w_q_nxt;
                    r_dvs <= r_dvs >> 1;
                    r_k   <= r_k - KW'(1);
                    if (w_last) begin
                        r_phase <= w_q_final;
                        r_sat   <= 1'b0;
                        r_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.phase_deg = r_phase;
    assign bus.sat       = r_sat;
    assign bus.err       = r_err;

endmodule

// File: tb/tb_phase_angle_calc.sv
// -----------------------------------------------------------------------------
// tb_phase_angle_calc
//   Directed and randomized checks for phase_angle_calc with default
//   parameters (CNT_W=64, FRAC_BITS=8, ANGLE_W=17).
// -----------------------------------------------------------------------------
module tb_phase_angle_calc;

    localparam int CNT_W   = 64;
    localparam int ANGLE_W = 17;
    localparam int MAX_DEG = 92159;

    logic sysClk;
    logic sysRst;
    int   total;
    int   bad;

    phase_angle_calc_if #(.CNT_W(CNT_W), .ANGLE_W(ANGLE_W)) bus ();

    phase_angle_calc dut (
        .sysClk (sysClk),
        .sysRst (sysRst),
        .bus    (bus)
    );

    initial sysClk = 1'b0;
    always #5 sysClk = ~sysClk;

    // Expected angle from plain wide arithmetic.
    function automatic logic [ANGLE_W-1:0] ref_angle(input logic [63:0] d, input logic [63:0] p);
        logic [127:0] num;
        logic [127:0] den;
        logic [127:0] q;
        logic [127:0] r;
        num = {64'd0, d} * 128'd92160;
        den = {64'd0, p};
        q   = num / den;
        r   = num % den;
`ifdef PHASE_ANGLE_ROUND_EN
        if ((r << 1) >= den) q = q + 128'd1;
        if (q > 128'd92159) q = 128'd92159;
`else
        if (r > den) q = 128'd0;  // unreachable: remainder is always below den
`endif
        return q[ANGLE_W-1:0];
    endfunction

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    // Present operands for one edge; afterwards scramble the bus so only the
    // latched copies can produce the result.
    task automatic start_op(input logic [63:0] d, input logic [63:0] p);
        bus.in_valid     = 1'b1;
        bus.diff_count   = d;
        bus.period_count = p;
        tick();
        bus.in_valid     = 1'b0;
        bus.diff_count   = 64'hDEAD_BEEF_0BAD_F00D;
        bus.period_count = 64'd3;
    endtask

    // Cycles from the accepting edge until out_valid is seen (bounded).
    task automatic wait_result(output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        sysRst = 1'b1;
        repeat (3) tick();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.phase_deg !== 17'd0) begin bad++; $display("FAIL reset_phase: got %0d want 0", bus.phase_deg); end
        total++; if (bus.sat !== 1'b0) begin bad++; $display("FAIL reset_sat: got %b want 0", bus.sat); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", bus.err); end
        sysRst = 1'b0;
    endtask

    task automatic test_divide();
        logic [63:0]        d_tab [4] = '{64'd25, 64'd1, 64'd1, 64'd3};
        logic [63:0]        p_tab [4] = '{64'd100, 64'd7, 64'd3, 64'd4};
        logic [ANGLE_W-1:0] e_tab [4];
        int lat;
`ifdef PHASE_ANGLE_ROUND_EN
        e_tab = '{17'd23040, 17'd13166, 17'd30720, 17'd69120};
`else
        e_tab = '{17'd23040, 17'd13165, 17'd30720, 17'd69120};
`endif
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL div_in_ready[%0d]: got %b want 1", i, bus.in_ready); end
            start_op(d_tab[i], p_tab[i]);
            wait_result(lat);
            total++; if (lat != 18) begin bad++; $display("FAIL div_latency[%0d]: got %0d want 18", i, lat); end
            total++; if (bus.phase_deg !== e_tab[i]) begin bad++; $display("FAIL div_phase[%0d]: got %0d want %0d", i, bus.phase_deg, e_tab[i]); end
            total++; if (bus.sat !== 1'b0 || bus.err !== 1'b0) begin bad++; $display("FAIL div_flags[%0d]: got sat=%b err=%b want 0 0", i, bus.sat, bus.err); end
            consume();
        end
    endtask

    task automatic test_sat_err();
        logic [63:0]        d_tab [4] = '{64'd100, 64'd0, 64'd200, 64'd7};
        logic [63:0]        p_tab [4] = '{64'd100, 64'd0, 64'd100, 64'd0};
        logic [ANGLE_W-1:0] e_tab [4] = '{17'd92159, 17'd0, 17'd92159, 17'd0};
        logic               s_tab [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic               r_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 4; i++) begin
            start_op(d_tab[i], p_tab[i]);
            wait_result(lat);
            total++; if (lat != 1) begin bad++; $display("FAIL se_latency[%0d]: got %0d want 1", i, lat); end
            total++; if (bus.phase_deg !== e_tab[i]) begin bad++; $display("FAIL se_phase[%0d]: got %0d want %0d", i, bus.phase_deg, e_tab[i]); end
            total++; if (bus.sat !== s_tab[i]) begin bad++; $display("FAIL se_sat[%0d]: got %b want %b", i, bus.sat, s_tab[i]); end
            total++; if (bus.err !== r_tab[i]) begin bad++; $display("FAIL se_err[%0d]: got %b want %b", i, bus.err, r_tab[i]); end
            consume();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        start_op(64'd25, 64'd100);
        wait_result(lat);
        total++; if (lat != 18) begin bad++; $display("FAIL bp_latency: got %0d want 18", lat); end
        // New operands offered while the result is stalled.
        bus.in_valid     = 1'b1;
        bus.diff_count   = 64'd50;
        bus.period_count = 64'd100;
        for (int i = 0; i < 5; i++) begin
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid[%0d]: got %b want 1", i, bus.out_valid); end
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, bus.in_ready); end
            total++; if (bus.phase_deg !== 17'd23040) begin bad++; $display("FAIL bp_phase[%0d]: got %0d want 23040", i, bus.phase_deg); end
            total++; if (bus.sat !== 1'b0 || bus.err !== 1'b0) begin bad++; $display("FAIL bp_flags[%0d]: got sat=%b err=%b want 0 0", i, bus.sat, bus.err); end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
        // in_valid is still high: accepted on this edge, exactly once.
        tick();
        bus.in_valid     = 1'b0;
        bus.diff_count   = 64'd1;
        bus.period_count = 64'd2;
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_accept_once: got in_ready=%b want 0", bus.in_ready); end
        wait_result(lat);
        total++; if (lat != 18) begin bad++; $display("FAIL bp2_latency: got %0d want 18", lat); end
        total++; if (bus.phase_deg !== 17'd46080) begin bad++; $display("FAIL bp2_phase: got %0d want 46080", bus.phase_deg); end
        consume();
        tick();
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_idle: got valid=%b ready=%b want 0 1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_reset_mid_div();
        int lat;
        bit seen;
        start_op(64'd25, 64'd100);
        // Edges 1..12 after accept; edge 13 is the k=5 divide step.
        repeat (12) tick();
        sysRst = 1'b1;
        tick();
        sysRst = 1'b0;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_in_ready: got %b want 1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_out_valid: got %b want 0", bus.out_valid); end
        total++; if (bus.phase_deg !== 17'd0) begin bad++; $display("FAIL mid_rst_phase: got %0d want 0", bus.phase_deg); end
        total++; if (bus.sat !== 1'b0 || bus.err !== 1'b0) begin bad++; $display("FAIL mid_rst_flags: got sat=%b err=%b want 0 0", bus.sat, bus.err); end
        seen = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        total++; if (seen) begin bad++; $display("FAIL mid_rst_no_pulse: got out_valid pulse want none"); end
        start_op(64'd50, 64'd100);
        wait_result(lat);
        total++; if (lat != 18) begin bad++; $display("FAIL mid_rst_next_latency: got %0d want 18", lat); end
        total++; if (bus.phase_deg !== 17'd46080) begin bad++; $display("FAIL mid_rst_next_phase: got %0d want 46080", bus.phase_deg); end
        consume();
    endtask

    task automatic test_sweep();
        logic [63:0]        d;
        logic [63:0]        p;
        logic [ANGLE_W-1:0] exp_q;
        int lat;
        int nbad_q;
        int nbad_lat;
        nbad_q   = 0;
        nbad_lat = 0;
        for (int i = 0; i < 1000; i++) begin
            case (i % 3)
                0: begin
                    d = 64'h8000_0000_0000_0000 | {32'd0, $urandom};
                    p = d + 64'd1 + {48'd0, 16'($urandom)};
                end
                1: begin
                    p = {$urandom, $urandom} | 64'd1;
                    d = {$urandom, $urandom} % p;
                end
                default: begin
                    p = 64'($urandom_range(1, 1000));
                    d = 64'($urandom) % p;
                end
            endcase
            exp_q = ref_angle(d, p);
            start_op(d, p);
            wait_result(lat);
            total++;
            if (lat != 18) begin
                bad++; nbad_lat++;
                if (nbad_lat <= 5) $display("FAIL sweep_latency[%0d]: got %0d want 18", i, lat);
            end
            total++;
            if (bus.phase_deg !== exp_q) begin
                bad++; nbad_q++;
                if (nbad_q <= 5) $display("FAIL sweep_phase[%0d]: d=%0d p=%0d got %0d want %0d", i, d, p, bus.phase_deg, exp_q);
            end
            consume();
        end
    endtask

    initial begin
        total            = 0;
        bad              = 0;
        sysRst           = 1'b1;
        bus.in_valid     = 1'b0;
        bus.out_ready    = 1'b0;
        bus.diff_count   = '0;
        bus.period_count = '0;

        test_reset();
        test_divide();
        test_sat_err();
        test_backpressure();
        test_reset_mid_div();
        test_sweep();

        if (MAX_DEG != 92159) bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
